// File: rtl/serial_pattern_sched.sv
// serial_pattern_sched
//
// Accepts a DATA_W-bit word over a valid/ready handshake, shifts it MSB-first
// through a PAT_W-bit sliding-window detector (one bit per clock), counts the
// pattern matches and presents a result record over a second valid/ready
// handshake.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   in_valid     producer has a word
//   in_ready     block can accept (IDLE only)
//   in_data      word to scan, MSB first
//   pattern      pattern to detect, sampled at acceptance
//   out_valid    result record valid (REPORT only)
//   out_ready    consumer takes the result
//   match_count  number of matches in the word
//   found        at least one match
//   first_pos    bit index (0 = MSB) where the first match completed
//   busy         state != IDLE
//
// Configuration macro:
//   SERIAL_PATTERN_OVERLAP_EN  defined     -> overlapping matches are counted
//                              not defined -> after a match PAT_W fresh bits
//                                             are needed for the next one
module serial_pattern_sched #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [PAT_W-1:0]            pattern,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(DATA_W+1)-1:0] match_count,
  output logic                        found,
  output logic [$clog2(DATA_W)-1:0]   first_pos,
  output logic                        busy
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int POS_W  = $clog2(DATA_W);
  localparam int FILL_W = $clog2(PAT_W + 1);

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  // fill + 1 >= PAT_W is the same as fill >= PAT_W - 1
  localparam logic [FILL_W-1:0] FILL_HIT = FILL_W'(PAT_W - 1);
  localparam logic [POS_W-1:0]  LAST_IDX = POS_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    REPORT = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sreg_q, sreg_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [PAT_W-1:0]    window_q, window_d;
  logic [POS_W-1:0]    bit_idx_q, bit_idx_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                found_q, found_d;
  logic [POS_W-1:0]    pos_q, pos_d;

  logic                shift_bit;
  logic [PAT_W-1:0]    window_next;
  logic                hit;

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    pat_d     = pat_q;
    window_d  = window_q;
    bit_idx_d = bit_idx_q;
    fill_d    = fill_q;
    count_d   = count_q;
    found_d   = found_q;
    pos_d     = pos_q;

    shift_bit   = sreg_q[DATA_W-1];
    window_next = {window_q[PAT_W-2:0], shift_bit};
    hit         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d    = in_data;
          pat_d     = pattern;
          window_d  = '0;
          bit_idx_d = '0;
          fill_d    = '0;
          count_d   = '0;
          found_d   = 1'b0;
          pos_d     = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        sreg_d   = {sreg_q[DATA_W-2:0], 1'b0};
        window_d = window_next;
        fill_d   = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + FILL_W'(1);

        // The window only counts once PAT_W real bits have entered it,
        // including the bit being shifted in this cycle.
        hit = (fill_q >= FILL_HIT) && (window_next == pat_q);

        if (hit) begin
          count_d = count_q + CNT_W'(1);
          if (!found_q) begin
            found_d = 1'b1;
            pos_d   = bit_idx_q;
          end
`ifndef SERIAL_PATTERN_OVERLAP_EN
          // Consume the matched bits: the next match needs PAT_W new ones.
          fill_d = '0;
`endif
        end

        if (bit_idx_q == LAST_IDX) begin
          state_d = REPORT;
        end else begin
          bit_idx_d = bit_idx_q + POS_W'(1);
        end
      end

      REPORT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      pat_q     <= '0;
      window_q  <= '0;
      bit_idx_q <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      found_q   <= 1'b0;
      pos_q     <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      pat_q     <= pat_d;
      window_q  <= window_d;
      bit_idx_q <= bit_idx_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      found_q   <= found_d;
      pos_q     <= pos_d;
    end
  end

  // All outputs come straight from flops or from a decode of the state flop.
  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == REPORT);
  assign busy        = (state_q != IDLE);
  assign match_count = count_q;
  assign found       = found_q;
  assign first_pos   = pos_q;

endmodule

// File: tb/tb_serial_pattern_sched.sv
// Testbench for serial_pattern_sched: directed vectors with literal
// expectations plus randomized words, handshake backpressure and resets,
// all compared every cycle against a word-level reference model.
module tb_serial_pattern_sched;

  localparam int DATA_W = 8;
  localparam int PAT_W  = 4;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int POS_W  = $clog2(DATA_W);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic [PAT_W-1:0]  pattern = '0;
  logic              in_ready;
  logic              out_valid;
  logic [CNT_W-1:0]  match_count;
  logic              found;
  logic [POS_W-1:0]  first_pos;
  logic              busy;

  serial_pattern_sched #(.DATA_W(DATA_W), .PAT_W(PAT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .pattern     (pattern),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .match_count (match_count),
    .found       (found),
    .first_pos   (first_pos),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             found;
    logic [POS_W-1:0] pos;
  } res_t;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level reference: scan the bits MSB-first and count every position
  // whose last PAT_W bits equal the pattern. Without overlap, a match uses
  // up its bits, so at least PAT_W fresh bits must follow before the next.
  function automatic res_t ref_scan(input logic [DATA_W-1:0] d, input logic [PAT_W-1:0] p);
    res_t r;
    int   fresh;
    int   w;
    r = '0;
    fresh = 0;
    for (int i = 0; i < DATA_W; i++) begin
      fresh++;
      w = (int'(d) >> (DATA_W - 1 - i)) & ((1 << PAT_W) - 1);
      if (fresh >= PAT_W && w == int'(p)) begin
        if (!r.found) begin
          r.found = 1'b1;
          r.pos   = POS_W'(i);
        end
        r.cnt = r.cnt + 1'b1;
`ifndef SERIAL_PATTERN_OVERLAP_EN
        fresh = 0;
`endif
      end
    end
    return r;
  endfunction

  // Cycle model: 0 = idle, 1 = scanning (m_left bits to go), 2 = reporting.
  int   m_phase = 0;
  int   m_left  = 0;
  res_t m_res   = '0;
  bit   m_zero  = 1'b1;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_phase <= 0;
      m_left  <= 0;
      m_res   <= '0;
      m_zero  <= 1'b1;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_phase <= 1;
          m_left  <= DATA_W;
          m_res   <= ref_scan(in_data, pattern);
          m_zero  <= 1'b0;
        end
        1: begin
          if (m_left == 1) m_phase <= 2;
          m_left <= m_left - 1;
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  // Single compare process: handshake flags every cycle, the record whenever
  // it is meaningful (reporting, or freshly reset).
  always @(negedge clk) begin
    if (chk_on) begin
      chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
      chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      if (m_phase == 2 || m_zero) begin
        chk("match_count", 32'(match_count), 32'(m_res.cnt));
        chk("found", 32'(found), 32'(m_res.found));
        chk("first_pos", 32'(first_pos), 32'(m_res.pos));
      end
    end
  end

  // Waits (bounded) until out_valid is seen #2 after an edge.
  task automatic wait_out(input string nm, output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #2;
      lat++;
    end
    if (!out_valid) chk({nm, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  task automatic run_word(input logic [DATA_W-1:0] d, input logic [PAT_W-1:0] p,
                          input int ec, input int ef, input int ep, input string nm);
    int lat;
    @(posedge clk); #2;
    in_valid = 1'b1; in_data = d; pattern = p; out_ready = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0; in_data = ~d; pattern = ~p;
    wait_out(nm, lat);
    chk({nm, "_latency"}, 32'(lat), 32'(DATA_W));
    chk({nm, "_count"}, 32'(match_count), 32'(ec));
    chk({nm, "_found"}, 32'(found), 32'(ef));
    chk({nm, "_pos"}, 32'(first_pos), 32'(ep));
    $display("word %h pat %b -> count=%0d found=%0d pos=%0d lat=%0d (%s)",
             d, p, match_count, found, first_pos, lat, nm);
  endtask

  initial begin
    res_t r;
    int   lat;
    int   cyc;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] tmp;
    int   c_aa, c_ff;

`ifdef SERIAL_PATTERN_OVERLAP_EN
    c_aa = 3; c_ff = 5;
`else
    c_aa = 2; c_ff = 2;
`endif

    // Pin the reference model to hand-computed values.
    r = ref_scan(8'b1011_1011, 4'b1011);
    chk("model_basic", 32'(r), 32'({4'd2, 1'b1, 3'd3}));
    r = ref_scan(8'hAA, 4'b1010);
    chk("model_aa", 32'(r), 32'({4'(c_aa), 1'b1, 3'd3}));
    r = ref_scan(8'hFF, 4'b1111);
    chk("model_ff", 32'(r), 32'({4'(c_ff), 1'b1, 3'd3}));
    r = ref_scan(8'hFF, 4'b0000);
    chk("model_none", 32'(r), 32'd0);

    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    chk_on = 1'b1;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    reset_n = 1'b1;

    run_word(8'b1011_1011, 4'b1011, 2, 1, 3, "basic");
    run_word(8'hAA, 4'b1010, c_aa, 1, 3, "overlap");
    run_word(8'hFF, 4'b1111, c_ff, 1, 3, "saturated");
    run_word(8'hFF, 4'b0000, 0, 0, 0, "nomatch");

    // Reset in the middle of a scan: accept at E0, reset at E4.
    @(posedge clk); #2;
    in_valid = 1'b1; in_data = 8'hFF; pattern = 4'b1111;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_count", 32'(match_count), 32'd0);
    chk("midrst_found", 32'(found), 32'd0);
    chk("midrst_pos", 32'(first_pos), 32'd0);
    $display("reset mid-scan -> in_ready=%0d out_valid=%0d", in_ready, out_valid);
    run_word(8'b1011_1011, 4'b1011, 2, 1, 3, "after_reset");

    // Backpressure in REPORT with a competing new word on the input side.
    @(posedge clk); #2;
    in_valid = 1'b1; in_data = 8'b1011_1011; pattern = 4'b1011; out_ready = 1'b0;
    @(posedge clk); #2;
    in_valid = 1'b0;
    wait_out("bp", lat);
    in_valid = 1'b1; in_data = 8'hAA; pattern = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #2;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_count", 32'(match_count), 32'd2);
      chk("bp_pos", 32'(first_pos), 32'd3);
      $display("backpressure cycle %0d: out_valid=%0d in_ready=%0d count=%0d", k, out_valid, in_ready, match_count);
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #2;
    chk("bp_second_busy", 32'(busy), 32'd1);
    in_valid = 1'b0; in_data = 8'h00; pattern = 4'b0000;
    wait_out("bp2", lat);
    chk("bp2_latency", 32'(lat), 32'(DATA_W));
    chk("bp2_count", 32'(match_count), 32'(c_aa));
    chk("bp2_found", 32'(found), 32'd1);
    $display("second word AA/1010 -> count=%0d lat=%0d", match_count, lat);

    // Randomized words with random backpressure, ignored in_valid and resets.
    for (int w = 0; w < 60; w++) begin
      @(posedge clk); #2;
      reset_n = 1'b1;
      out_ready = 1'b1;
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
      rd = DATA_W'($urandom);
      in_data = rd;
      if ($urandom_range(0, 1) == 1) begin
        tmp = rd >> $urandom_range(0, DATA_W - PAT_W);
        pattern = tmp[PAT_W-1:0];
      end else begin
        pattern = PAT_W'($urandom);
      end
      in_valid = 1'b1;
      @(posedge clk); #2;
      $display("rand word %0d: data %h pat %b expect count=%0d found=%0d pos=%0d",
               w, rd, pattern, m_res.cnt, m_res.found, m_res.pos);
      cyc = 0;
      while (m_phase != 0 && cyc < 200) begin
        in_valid  = ($urandom_range(0, 1) == 1);
        in_data   = DATA_W'($urandom);
        pattern   = PAT_W'($urandom);
        out_ready = ($urandom_range(0, 2) != 0);
        reset_n   = ($urandom_range(0, 149) != 0);
        @(posedge clk); #2;
        cyc++;
      end
      in_valid = 1'b0;
      if (m_phase != 0) chk("rand_timeout", 32'(m_phase), 32'd0);
    end

    reset_n = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_pattern_sched.md
# serial_pattern_sched

Byte-stream controller that sequences a Moore-style serial pattern detector. It accepts a parallel byte over a valid/ready handshake and shifts it MSB-first through an internal 4-bit sliding-window detector, one bit per clock. It counts pattern matches and returns a result record over a second valid/ready handshake. It sits between a word-oriented producer (bus, FIFO) and consumer logic, replacing hand-driven single-bit stimulus of the detector FSMs.

## Interface
Parameters:
- DATA_W, 8, bits per accepted word; legal range 4..16.
- PAT_W, 4, pattern and window width; fixed at 4 in this revision.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept; high only in IDLE.
- in_data  input  DATA_W  word to scan, MSB first.
- pattern  input  PAT_W  pattern to detect; sampled at the acceptance edge only.
- out_valid  output  1  result record valid; high only in REPORT.
- out_ready  input  1  consumer takes the result.
- match_count  output  $clog2(DATA_W+1)  number of matches in the word (4 bits at default).
- found  output  1  at least one match.
- first_pos  output  $clog2(DATA_W)  bit index (0 = MSB) at which the first match completed; 0 when found=0.
- busy  output  1  state != IDLE.

## Operation
- States: IDLE, SHIFT, REPORT. Encoding is free; an illegal state goes to IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch in_data into the shift register and pattern into pat_q;
  - clear window, bit counter, fill counter, match_count, found and first_pos;
  - go to SHIFT.
- SHIFT: each cycle, take the shift-register MSB as bit b and shift left.
  - window <= {window[PAT_W-2:0], b}; fill counter increments and saturates at PAT_W.
  - A match occurs when fill counter + 1 >= PAT_W and {window[PAT_W-2:0], b} == pat_q.
  - On a match, match_count increments. On the first match only, found <= 1 and first_pos <= bit index.
  - After bit index DATA_W-1 is processed, go to REPORT.
- REPORT: out_valid=1; match_count, found and first_pos are held stable. On out_valid&&out_ready, go to IDLE.
- in_ready and out_valid are never high in the same cycle. There is no bypass: a new word is accepted at the earliest one cycle after the result handshake.
- in_valid is ignored outside IDLE. in_data and pattern are don't-care outside the acceptance edge.
- match_count cannot overflow: at most DATA_W-PAT_W+1 matches per word.

## Timing
- Reset (reset_n=0 at an edge) gives state IDLE and in_ready=1, out_valid=0, busy=0, match_count=0, found=0, first_pos=0. Window and counters are cleared.
- Reset has priority in every state. Reset mid-SHIFT or mid-REPORT discards the word and its result; out_valid=0 after that edge.
- Latency: acceptance at edge E0; bits 0..DATA_W-1 are processed at edges E1..E(DATA_W); out_valid is high from the cycle after E(DATA_W). At default, that is 8 cycles after acceptance.
- Throughput: one word per DATA_W+2 cycles when out_ready is held high.
- All outputs are registered or decoded from the state register only; no input-to-output combinational path.

## Configuration
- SERIAL_PATTERN_OVERLAP_EN defined: overlapping matches count. The window keeps sliding after a match.
- Not defined: non-overlapping. On a match, the fill counter clears to 0, so the next match needs PAT_W fresh bits. match_count, found and first_pos otherwise behave identically.

## Test plan
- Reset mid-SHIFT: accept 8'hFF with pattern 4'b1111, assert reset_n=0 for one edge at E4 -> next cycle in_ready=1, out_valid=0, all outputs 0; a fresh word then completes normally.
- Basic: in_data=8'b1011_1011, pattern=4'b1011 -> out_valid 8 cycles after acceptance, match_count=2, found=1, first_pos=3, in both configurations.
- Overlap: in_data=8'hAA, pattern=4'b1010 -> with macro: count=3, first_pos=3; without: count=2, first_pos=3.
- Saturated run: in_data=8'hFF, pattern=4'b1111 -> with macro: count=5; without: count=2; found=1, first_pos=3.
- No match: in_data=8'hFF, pattern=4'b0000 -> count=0, found=0, first_pos=0.
- Backpressure: hold out_ready=0 for 5 cycles in REPORT with in_valid=1 and a new in_data -> outputs stable, in_ready=0, no acceptance. Raise out_ready -> IDLE next cycle, second word accepted one cycle later and pattern re-sampled.
